// File: rtl/i2c_arbiter_pkg.sv
// i2c_pkg: shared types and constants for the I2C master arbiter.
//   arb_state_t  - arbiter FSM state (IDLE / BUSY / GAP)
//   i2c_cmd_t    - command bits forwarded to the I2C master
//   onehot_idx() - index of the set bit in a one-hot vector of up to 8 bits
package i2c_pkg;

    localparam int unsigned I2C_ADDR_W = 7;
    localparam int unsigned I2C_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                  high_speed;
        logic                  read;
        logic [I2C_ADDR_W-1:0] addr;
    } i2c_cmd_t;

    // NUM_REQ is capped at 8, so an 8-bit one-hot covers every legal configuration.
    function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/i2c_arbiter_if.sv
// i2c_arbiter_if: cmd/data handshake bundle between an I2C command source and an I2C master.
// Lanes > 1 carries one lane per requester; data_out is a single broadcast byte.
//   master modport: drives cmd_* / data_valid / data_in, receives data_ready / data_out
//   slave modport : the opposite direction
interface i2c_arbiter_if
    import i2c_pkg::*;
#(
    parameter int unsigned Lanes = 1
);
    logic [Lanes-1:0]                 cmd_active;
    logic [Lanes-1:0]                 cmd_high_speed;
    logic [Lanes-1:0]                 cmd_read;
    logic [Lanes-1:0][I2C_ADDR_W-1:0] cmd_addr;
    logic [Lanes-1:0]                 data_valid;
    logic [Lanes-1:0][I2C_DATA_W-1:0] data_in;
    logic [Lanes-1:0]                 data_ready;
    logic [I2C_DATA_W-1:0]            data_out;

    modport master (
        output cmd_active, cmd_high_speed, cmd_read, cmd_addr, data_valid, data_in,
        input  data_ready, data_out
    );

    modport slave (
        input  cmd_active, cmd_high_speed, cmd_read, cmd_addr, data_valid, data_in,
        output data_ready, data_out
    );
endinterface

// File: rtl/i2c_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selection.
//   req    - eligible request vector
//   rr_ptr - lowest index given priority this round
//   winner - one-hot first set bit at or after rr_ptr, wrapping to bit 0
//   valid  - any request present
module rr_picker #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [NUM_REQ-1:0] req_hi;
    logic [NUM_REQ-1:0] pick;

    always_comb begin
        // Requests at or above the pointer take priority; otherwise wrap to the full set.
        req_hi = req & ({NUM_REQ{1'b1}} << rr_ptr);
        pick   = (|req_hi) ? req_hi : req;
        // Isolate the lowest set bit.
        winner = pick & (~pick + ONE);
        valid  = |req;
    end

endmodule

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: shares one I2C master between NUM_REQ requesters.
//   clk               - clk_peripheral domain clock
//   reset             - asynchronous active-high reset
//   req               - per-requester cmd/data lanes (Lanes = NUM_REQ)
//   mst               - single-lane link to the I2C master
//   req_grant         - one-hot current grant
//   req_timeout       - sticky per-requester watchdog flag
//   req_timeout_clear - clears the matching timeout flag (a same-cycle set wins)
// Grants are round-robin and held for a whole transaction, followed by GAP_CYCLES of
// forced idle so the master can issue STOP. A watchdog revokes a stalled grant; the
// revoked requester must drop cmd_active before it can be granted again.
module i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               reset,
    i2c_arbiter_if.slave       req,
    i2c_arbiter_if.master      mst,
    output logic [NUM_REQ-1:0] req_grant,
    output logic [NUM_REQ-1:0] req_timeout,
    input  logic [NUM_REQ-1:0] req_timeout_clear
);

    localparam int unsigned PTR_W  = $clog2(NUM_REQ);
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GAP_W  = 4;

    arb_state_t         state_q;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   g_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] timeout_q;
    logic [NUM_REQ-1:0] blocked_q;
    logic [WDOG_W-1:0]  wdog_q;
    logic [GAP_W-1:0]   gap_q;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   g_next;
    logic [WDOG_W-1:0]  wdog_inc;
    logic               busy;
    logic               g_active;
    logic               g_valid;
    logic               expire;
    logic [NUM_REQ-1:0] revoke_set;
    i2c_cmd_t           g_cmd;
    logic [I2C_DATA_W-1:0] g_data;

    assign eligible = req.cmd_active & ~blocked_q;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_picker (
        .req    (eligible),
        .rr_ptr (rr_ptr_q),
        .winner (pick_oh),
        .valid  (pick_valid)
    );

    assign pick_idx = PTR_W'(onehot_idx(8'(pick_oh)));

    always_comb begin
        busy     = (state_q == BUSY);
        g_active = busy & req.cmd_active[g_q];
        g_valid  = busy & req.data_valid[g_q];
        wdog_inc = (wdog_q == WDOG_W'(TIMEOUT_CYCLES)) ? wdog_q : wdog_q + WDOG_W'(1);
        // Expiry only while the requester still holds the transaction open.
        expire     = g_active & ~g_valid & (wdog_inc == WDOG_W'(TIMEOUT_CYCLES));
        revoke_set = expire ? grant_q : '0;
        g_next     = (g_q == PTR_W'(NUM_REQ - 1)) ? '0 : g_q + PTR_W'(1);
        g_cmd  = '0;
        g_data = '0;
        if (busy) begin
            g_cmd.high_speed = req.cmd_high_speed[g_q];
            g_cmd.read       = req.cmd_read[g_q];
            g_cmd.addr       = req.cmd_addr[g_q];
            g_data           = req.data_in[g_q];
        end
    end

    // Master side follows the granted lane combinationally; everything is zero outside BUSY,
    // so an asynchronous reset drops cmd_active without waiting for a clock edge.
    assign mst.cmd_active     = g_active;
    assign mst.cmd_high_speed = g_cmd.high_speed;
    assign mst.cmd_read       = g_cmd.read;
    assign mst.cmd_addr       = g_cmd.addr;
    assign mst.data_valid     = g_valid;
    assign mst.data_in        = g_data;

    assign req.data_ready = busy ? (grant_q & {NUM_REQ{mst.data_ready}}) : '0;
    assign req.data_out   = mst.data_out;
    assign req_grant      = grant_q;
    assign req_timeout    = timeout_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            g_q       <= '0;
            grant_q   <= '0;
            timeout_q <= '0;
            blocked_q <= '0;
            wdog_q    <= '0;
            gap_q     <= '0;
        end else begin
            timeout_q <= (timeout_q & ~req_timeout_clear) | revoke_set;
            // A blocked requester is freed by any cycle with cmd_active low.
            blocked_q <= (blocked_q & req.cmd_active) | revoke_set;
            unique case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q <= BUSY;
                        grant_q <= pick_oh;
                        g_q     <= pick_idx;
                        wdog_q  <= '0;
                    end
                end
                BUSY: begin
                    if (!req.cmd_active[g_q] || expire) begin
                        state_q  <= GAP;
                        grant_q  <= '0;
                        rr_ptr_q <= g_next;
                        gap_q    <= '0;
                    end else if (g_valid) begin
                        wdog_q <= '0;
                    end else begin
                        wdog_q <= wdog_inc;
                    end
                end
                GAP: begin
                    if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/i2c_arbiter.md
# i2c_arbiter

Shares one I2C master (cmd/data handshake interface) between `NUM_REQ` requesters: PLL-A configuration sequencer, PLL-B sequencer, APB software access. Round-robin grant, held for a whole transaction (from `req_cmd_active` rise to fall), followed by a guaranteed idle gap so the master can issue STOP. A watchdog forcibly revokes a grant from a requester that stalls. Sits in the board controller between the configuration state machines and the single I2C master instance.

## Interface
- `NUM_REQ`, 3: number of requesters (2..8).
- `GAP_CYCLES`, 4: cycles `cmd_active` is held low between grants (1..15).
- `TIMEOUT_CYCLES`, 65535: max cycles a granted requester may leave `req_data_valid` low while `req_cmd_active` is high.
- `clk`  in  1  clock, `clk_peripheral` domain.
- `reset`  in  1  asynchronous, active-high reset.
- `req_cmd_active`  in  NUM_REQ  per requester: transaction request/hold.
- `req_cmd_high_speed`, `req_cmd_read`  in  NUM_REQ each  per-requester command bits.
- `req_cmd_addr`  in  NUM_REQ×7  7-bit slave addresses.
- `req_data_valid`  in  NUM_REQ  byte offered / read byte requested.
- `req_data_in`  in  NUM_REQ×8  write bytes.
- `req_data_ready`  out  NUM_REQ  one-hot ready, only the granted bit may be 1.
- `req_data_out`  out  8  read byte, broadcast.
- `req_grant`  out  NUM_REQ  one-hot current grant.
- `req_timeout`  out  NUM_REQ  sticky per-requester timeout flag.
- `req_timeout_clear`  in  NUM_REQ  clear the matching flag.
- `cmd_active`, `cmd_high_speed`, `cmd_read`, `data_valid`  out  1 each  to I2C master.
- `cmd_addr`  out  7;  `data_in`  out  8  to I2C master.
- `data_ready`  in  1;  `data_out`  in  8  from I2C master.

## Operation
- States: IDLE, BUSY, GAP.
- IDLE: if any `req_cmd_active`, register winner = first set bit at or after `rr_ptr` (wrapping), go BUSY. No request: stay.
- BUSY: master-side outputs are combinational muxes of the granted requester. `cmd_active`/`data_valid` are gated by grant, never by any other requester. `req_data_ready[g] = data_ready`.
- BUSY exits to GAP when granted `req_cmd_active` falls, or on watchdog expiry. In both cases `rr_ptr <= (g+1) mod NUM_REQ` and `req_grant` is cleared.
- Watchdog: counter reset on entering BUSY and on every cycle with granted `req_data_valid` = 1. It increments otherwise; when it reaches TIMEOUT_CYCLES, set `req_timeout[g]` and revoke the grant.
- A revoked requester is not re-granted until it drops `req_cmd_active` for at least one cycle. Track this with a per-requester `blocked` bit.
- GAP: all master-side outputs 0 for GAP_CYCLES cycles, then IDLE.
- `req_timeout_clear[i]` and a same-cycle set on the same bit: set wins.
- Widths: watchdog counter is $clog2(TIMEOUT_CYCLES+1) bits, saturating. `rr_ptr` is $clog2(NUM_REQ) bits and wraps explicitly at NUM_REQ-1, not at a power of two.

## Timing
- Reset values:
  - State IDLE, `rr_ptr` 0.
  - `req_grant`, `req_data_ready`, `req_timeout`, blocked bits, `cmd_active`, `data_valid`: 0.
  - `cmd_addr`, `data_in`, `cmd_read`, `cmd_high_speed`: 0.
  - Reset asserted mid-transaction drops `cmd_active` immediately (asynchronous).
- Grant latency: request seen in IDLE at edge N; `req_grant` and `cmd_active` are high after edge N+1.
- Data path: zero added latency. `data_ready` reaches the granted requester in the same cycle.
- Release: `req_cmd_active` low at edge N; `cmd_active` is low after edge N+1 and stays low for exactly GAP_CYCLES cycles. The earliest next grant is after edge N+GAP_CYCLES+2.
- A requester dropping `req_cmd_active` while its `data_valid` is pending is released anyway. The master is responsible for aborting.

## Structure
- Package `i2c_pkg`:
  - `arb_state_t` enum (IDLE/BUSY/GAP).
  - `I2C_ADDR_W` = 7, `I2C_DATA_W` = 8.
  - Typedef `i2c_cmd_t` {high_speed, read, addr}.
- Sub-module `rr_picker`: combinational first-set-at-or-after-pointer, inputs `req & ~blocked` and `rr_ptr`, outputs one-hot winner and a `valid` bit.

## Test plan
- Single requester 0 writes 2 bytes (0x60 addr, 0x10, 0x4F) → master sees identical cmd/data; `cmd_active` high 1 cycle after request; ≥4 idle cycles after release.
- Requesters 0 and 2 assert the same cycle with `rr_ptr`=0 → 0 granted, then 2. Then 0 and 1 simultaneously → 0 granted (ptr=0 after 2), then 1.
- Requester 1 holds `cmd_active` with `data_valid`=0; TIMEOUT_CYCLES=16 → grant revoked on the 16th idle cycle, `req_timeout[1]`=1. No re-grant until it deasserts. `req_timeout_clear[1]` clears the flag.
- Non-granted requester 2 drives `data_valid`=1 during requester 0's transaction → master `data_valid` follows requester 0 only; `req_data_ready[2]` stays 0.
- Async `reset` pulse mid-byte → all outputs 0 without a clock edge. After release, a pending request is granted starting from `rr_ptr`=0.
